// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed hex 7-segment driver: scans one digit per slot on shared segment
// lines, with a frame-coherent input snapshot, blanking, zero suppression and dead time.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W:0]   DEAD_END = (CNT_W + 1)'(BLANK_CYCLES);

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;

  logic [CNT_W-1:0]        cnt;
  logic                    load_pending;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic                    snap_lz;

  logic                    frame_end;
  logic                    load_now;
  logic                    in_dead;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    upper_zero;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    cur_lz;
  logic [6:0]              seg_lit;
  logic                    dp_lit;
  logic [6:0]              seg_drive;
  logic                    dp_drive;
  logic [NUM_DIGITS-1:0]   an_drive;

  // Active-high segment pattern {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign frame_end = (cnt == CNT_LAST) && (digit_idx == IDX_LAST);
  assign load_now  = enable && (load_pending || frame_end);
  assign in_dead   = ({1'b0, cnt} < DEAD_END);

  // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (snap_digits[4*k +: 4] == 4'h0);
      lz_mask[k] = snap_lz && upper_zero;
    end
  end

  always_comb begin
    an_sel    = '0;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        an_sel[k] = 1'b1;
        cur_nib   = snap_digits[4*k +: 4];
        cur_dp    = snap_dp[k];
        cur_blank = snap_blank[k];
        cur_lz    = lz_mask[k];
      end
    end
  end

  always_comb begin
    seg_lit   = (cur_blank || cur_lz) ? 7'h00 : hex_decode(cur_nib);
    dp_lit    = cur_dp && !cur_blank;
    seg_drive = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
    dp_drive  = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
    // Dead time keeps anodes off while the segment lines settle on the new pattern.
    if (in_dead) an_drive = AN_OFF;
    else         an_drive = AN_ACTIVE_LOW ? ~an_sel : an_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      digit_idx    <= '0;
      load_pending <= 1'b1;
      snap_digits  <= '0;
      snap_dp      <= '0;
      snap_blank   <= '0;
      snap_lz      <= 1'b0;
      frame_tick   <= 1'b0;
      an_out       <= AN_OFF;
      seg_out      <= SEG_OFF;
      dp_out       <= DP_OFF;
    end else begin
      frame_tick <= load_now;
      if (load_now) begin
        snap_digits  <= digits_in;
        snap_dp      <= dp_in;
        snap_blank   <= blank_in;
        snap_lz      <= lz_suppress;
        load_pending <= 1'b0;
      end
      if (enable) begin
        if (cnt == CNT_LAST) begin
          cnt       <= '0;
          digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        an_out  <= an_drive;
        seg_out <= seg_drive;
        dp_out  <= dp_drive;
      end else begin
        an_out  <= AN_OFF;
        seg_out <= SEG_OFF;
        dp_out  <= DP_OFF;
      end
    end
  end

endmodule
